// File: rtl/rf_mp.sv
`default_nettype none
// ============================================================================
// Module   : rf_mp
// Purpose  : Register file with one write port, two synchronous read ports
//            with write bypass, sequenced clear-all and flat low-register export.
// Revision : 1.0
// ============================================================================
module rf_mp #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int NEXPORT = 5,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re_a,
    input  logic [AW-1:0]            raddr_a,
    output logic [WIDTH-1:0]         rdata_a,
    output logic                     rvalid_a,
    input  logic                     re_b,
    input  logic [AW-1:0]            raddr_b,
    output logic [WIDTH-1:0]         rdata_b,
    output logic                     rvalid_b,
    input  logic                     clr,
    output logic                     busy,
    output logic [NEXPORT*WIDTH-1:0] rf_data
);

    localparam logic [0:0]    c_IDLE  = 1'b0;
    localparam logic [0:0]    c_CLEAR = 1'b1;
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_ONE   = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [AW-1:0]    r_cnt;

    logic             w_busy;
    logic             w_op_ok;
    logic             w_wr_en;
    logic             w_rd_a;
    logic             w_rd_b;
    logic             w_waddr_ok;
    logic             w_raddr_a_ok;
    logic             w_raddr_b_ok;
    logic [WIDTH-1:0] w_rd_data_a;
    logic [WIDTH-1:0] w_rd_data_b;

    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_rvalid_a;
    logic             r_rvalid_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (clr)             w_state_nxt = c_CLEAR;
            c_CLEAR: if (r_cnt == c_LAST) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // clr in IDLE swallows any same-cycle write or read.
    always_comb begin
        w_busy  = (r_state == c_CLEAR);
        w_op_ok = (r_state == c_IDLE) && !clr;
    end

    always_comb begin
        w_waddr_ok   = {1'b0, waddr}   < c_DEPTH;
        w_raddr_a_ok = {1'b0, raddr_a} < c_DEPTH;
        w_raddr_b_ok = {1'b0, raddr_b} < c_DEPTH;
        w_wr_en      = w_op_ok && we && w_waddr_ok;
        w_rd_a       = w_op_ok && re_a;
        w_rd_b       = w_op_ok && re_b;
    end

    // Bypass only for in-range writes; out-of-range reads always return zero.
    always_comb begin
        w_rd_data_a = '0;
        if (w_wr_en && (waddr == raddr_a)) begin
            w_rd_data_a = wdata;
        end else if (w_raddr_a_ok) begin
            w_rd_data_a = r_mem[raddr_a];
        end
    end

    always_comb begin
        w_rd_data_b = '0;
        if (w_wr_en && (waddr == raddr_b)) begin
            w_rd_data_b = wdata;
        end else if (w_raddr_b_ok) begin
            w_rd_data_b = r_mem[raddr_b];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == c_CLEAR) begin
            r_cnt <= r_cnt + c_ONE;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == c_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= w_rd_a;
            r_rvalid_b <= w_rd_b;
            if (w_rd_a) begin
                r_rdata_a <= w_rd_data_a;
            end
            if (w_rd_b) begin
                r_rdata_b <= w_rd_data_b;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NEXPORT; gi++) begin : g_export
            assign rf_data[gi*WIDTH +: WIDTH] = r_mem[gi];
        end
    endgenerate

    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_rf_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_mp
// Purpose  : Scoreboard bench for rf_mp, default and non-power-of-2 configs.
// Revision : 1.0
// ============================================================================
module tb_rf_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        we0, re_a0, re_b0, clr0, rva0, rvb0, busy0;
    logic [3:0]  waddr0, ra0, rb0;
    logic [7:0]  wdata0, rda0, rdb0;
    logic [39:0] rf0;

    logic        we1, re_a1, re_b1, clr1, rva1, rvb1, busy1;
    logic [3:0]  waddr1, ra1, rb1;
    logic [15:0] wdata1, rda1, rdb1;
    logic [47:0] rf1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [15:0] q0a[$], q0b[$], q1a[$], q1b[$];

    rf_mp #(.WIDTH(8), .DEPTH(16), .NEXPORT(5)) u_dut0 (
        .clk(clk), .rst(rst), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .re_a(re_a0), .raddr_a(ra0), .rdata_a(rda0), .rvalid_a(rva0),
        .re_b(re_b0), .raddr_b(rb0), .rdata_b(rdb0), .rvalid_b(rvb0),
        .clr(clr0), .busy(busy0), .rf_data(rf0)
    );

    rf_mp #(.WIDTH(16), .DEPTH(12), .NEXPORT(3)) u_dut1 (
        .clk(clk), .rst(rst), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .re_a(re_a1), .raddr_a(ra1), .rdata_a(rda1), .rvalid_a(rva1),
        .re_b(re_b1), .raddr_b(rb1), .rdata_b(rdb1), .rvalid_b(rvb1),
        .clr(clr1), .busy(busy1), .rf_data(rf1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [15:0] d);
        n_chk++;
        n_fail++;
        $display("FAIL %s: rvalid with no expected read, data %h", nm, d);
    endtask

    // Monitor: pops the expected value whenever a port presents rvalid.
    always @(negedge clk) begin
        if (!rst) begin
            if (rva0) begin
                if (q0a.size() == 0) unexpected("rd0_a", {8'h00, rda0});
                else check("rd0_a", {8'h00, rda0}, q0a.pop_front());
            end
            if (rvb0) begin
                if (q0b.size() == 0) unexpected("rd0_b", {8'h00, rdb0});
                else check("rd0_b", {8'h00, rdb0}, q0b.pop_front());
            end
            if (rva1) begin
                if (q1a.size() == 0) unexpected("rd1_a", rda1);
                else check("rd1_a", rda1, q1a.pop_front());
            end
            if (rvb1) begin
                if (q1b.size() == 0) unexpected("rd1_b", rdb1);
                else check("rd1_b", rdb1, q1b.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        we0 = 1'b0; re_a0 = 1'b0; re_b0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic idle1();
        we1 = 1'b0; re_a1 = 1'b0; re_b1 = 1'b0; clr1 = 1'b0;
    endtask

    task automatic wr0(input logic [3:0] a, input logic [7:0] d);
        we0 = 1'b1; waddr0 = a; wdata0 = d;
        cyc();
        we0 = 1'b0;
    endtask

    task automatic rd0(input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] ea, input logic [7:0] eb);
        re_a0 = 1'b1; ra0 = a; re_b0 = 1'b1; rb0 = b;
        q0a.push_back({8'h00, ea});
        q0b.push_back({8'h00, eb});
        cyc();
        re_a0 = 1'b0; re_b0 = 1'b0;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [15:0] d);
        we1 = 1'b1; waddr1 = a; wdata1 = d;
        cyc();
        we1 = 1'b0;
    endtask

    task automatic rd1(input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] ea, input logic [15:0] eb);
        re_a1 = 1'b1; ra1 = a; re_b1 = 1'b1; rb1 = b;
        q1a.push_back(ea);
        q1b.push_back(eb);
        cyc();
        re_a1 = 1'b0; re_b1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst = 1'b1;
        idle0(); idle1();
        waddr0 = '0; wdata0 = '0; ra0 = '0; rb0 = '0;
        waddr1 = '0; wdata1 = '0; ra1 = '0; rb1 = '0;
        cyc(); cyc();
        check("rst_busy", busy0, 1'b0);
        check("rst_rf", rf0, 40'h0);
        check("rst_rdata", {rda0, rdb0}, 16'h0);
        check("rst_rvalid", {rva0, rvb0}, 2'b00);
        rst = 1'b0;
        cyc();

        // Every register reads zero after reset, both ports.
        for (int i = 0; i < 16; i++) rd0(i[3:0], 4'(15 - i), 8'h00, 8'h00);
        cyc();
        check("post_rst_busy", busy0, 1'b0);
        check("post_rst_rf", rf0, 40'h0);

        // Two-port read of freshly written registers.
        wr0(4'd3, 8'hA5);
        wr0(4'd4, 8'h3C);
        rd0(4'd3, 4'd4, 8'hA5, 8'h3C);
        cyc();
        check("export_3_4", rf0[39:24], 16'h3CA5);

        // Write-to-read bypass on both ports to the same address.
        wr0(4'd7, 8'h11);
        we0 = 1'b1; waddr0 = 4'd7; wdata0 = 8'h5A;
        rd0(4'd7, 4'd7, 8'h5A, 8'h5A);
        we0 = 1'b0;
        rd0(4'd7, 4'd3, 8'h5A, 8'hA5);
        cyc(); cyc();
        check("rdata_hold", rda0, 8'h5A);

        // Clear sequence: same-cycle write/read dropped, busy length fixed.
        for (int i = 0; i < 16; i++) wr0(i[3:0], 8'hFF);
        check("fill_rf", rf0, 40'hFF_FFFF_FFFF);
        clr0 = 1'b1; we0 = 1'b1; waddr0 = 4'd2; wdata0 = 8'h77;
        re_a0 = 1'b1; ra0 = 4'd2;
        cyc();
        idle0();
        cnt = 0;
        while (busy0 && cnt < 40) begin
            if (cnt == 0) check("clr_drops_wr", rf0[23:16], 8'hFF);
            if (cnt == 1) check("clr_progress", rf0[15:0], 16'hFF00);
            we0 = 1'b1; waddr0 = cnt[3:0]; wdata0 = 8'h55;
            re_a0 = 1'b1; ra0 = cnt[3:0]; re_b0 = 1'b1; rb0 = 4'd2;
            clr0 = (cnt == 3);
            cyc();
            cnt++;
        end
        idle0();
        check("busy_len16", cnt, 16);
        check("rdata_hold_busy", rda0, 8'h5A);
        cyc();
        check("clr_rf", rf0, 40'h0);
        for (int i = 0; i < 16; i++) rd0(i[3:0], 4'(15 - i), 8'h00, 8'h00);

        // Asynchronous reset in the middle of a clear.
        for (int i = 0; i < 16; i++) wr0(i[3:0], 8'hFF);
        clr0 = 1'b1;
        cyc();
        clr0 = 1'b0;
        repeat (5) cyc();
        check("busy_mid_clear", busy0, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy0, 1'b0);
        check("async_rst_rf", rf0, 40'h0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 16; i++) rd0(i[3:0], 4'(15 - i), 8'h00, 8'h00);
        check("post_abort_busy", busy0, 1'b0);

        // 16-bit x 12 configuration.
        wr1(4'd11, 16'hBEEF);
        rd1(4'd11, 4'd13, 16'hBEEF, 16'h0000);
        wr1(4'd0, 16'h1111);
        wr1(4'd1, 16'h2222);
        wr1(4'd2, 16'h3333);
        check("d1_export", rf1, 48'h3333_2222_1111);
        we1 = 1'b1; waddr1 = 4'd14; wdata1 = 16'h1234;
        rd1(4'd14, 4'd11, 16'h0000, 16'hBEEF);
        we1 = 1'b0;
        check("d1_oob_write", rf1, 48'h3333_2222_1111);
        rd1(4'd11, 4'd2, 16'hBEEF, 16'h3333);
        clr1 = 1'b1;
        cyc();
        clr1 = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 40) begin
            cyc();
            cnt++;
        end
        check("d1_busy_len12", cnt, 12);
        check("d1_clr_rf", rf1, 48'h0);
        rd1(4'd11, 4'd0, 16'h0000, 16'h0000);

        repeat (3) cyc();
        check("q0a_drained", q0a.size(), 0);
        check("q0b_drained", q0b.size(), 0);
        check("q1a_drained", q1a.size(), 0);
        check("q1b_drained", q1b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_mp.md
Name: rf_mp

Overview:
Parametrised general-purpose register file, the successor to the single-port 8-bit x16 register file used by the simple processor datapath.
- Adds one write port and two independent synchronous read ports (A/B) for two-operand instructions.
- Adds write-to-read bypass so back-to-back dependent instructions read fresh data.
- Adds a sequenced clear-all operation with a busy flag, and a flat read-only export of the low registers for the display/debug logic.

Parameters:
WIDTH, 8, data width of each register (>=1)
DEPTH, 16, number of registers (>=2)
NEXPORT, 5, number of low registers exported on rf_data (1..DEPTH)
AW (localparam), clog2(DEPTH), address width; not overridable

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
we  input  1  write enable
waddr  input  AW  write address
wdata  input  WIDTH  write data
re_a  input  1  read enable, port A
raddr_a  input  AW  read address, port A
rdata_a  output  WIDTH  registered read data, port A
rvalid_a  output  1  one-cycle pulse, rdata_a updated this cycle
re_b  input  1  read enable, port B
raddr_b  input  AW  read address, port B
rdata_b  output  WIDTH  registered read data, port B
rvalid_b  output  1  one-cycle pulse, rdata_b updated this cycle
clr  input  1  start clear-all sequence (level sampled per cycle)
busy  output  1  high while clear sequence runs
rf_data  output  NEXPORT*WIDTH  {reg[NEXPORT-1],...,reg[0]}, reg[0] in LSBs

Behaviour:
Clock and reset:
- One clock, clk; reset rst is asynchronous and active-high.
- Reset clears every register 0..DEPTH-1 (all entries, no off-by-one).
- Reset also forces rdata_a/b=0, rvalid_a/b=0, busy=0, state IDLE, clear counter=0.

State machine:
- States IDLE, CLEAR.
- IDLE & clr=1 -> CLEAR; busy=1 from the next cycle, counter=0.
- CLEAR: each cycle writes 0 to reg[counter], counter+1. After writing reg[DEPTH-1] -> IDLE, busy=0.
- Sequence is exactly DEPTH cycles with busy=1.
- clr while busy is ignored; the sequence does not restart.

Write:
- In IDLE with clr=0, we=1 writes reg[waddr]<=wdata at the edge.
- waddr>=DEPTH (non-power-of-2 DEPTH) is ignored.

Read (per port, independent):
- In IDLE with clr=0, re_x=1 gives a 1-cycle latency: next cycle rdata_x holds the data and rvalid_x=1 for one cycle.
- Bypass: if we=1 and waddr==raddr_x in the same cycle, rdata_x=wdata (new value), not the old contents.
- raddr_x>=DEPTH returns 0 with rvalid_x=1.
- re_x=0: rdata_x holds its previous value, rvalid_x=0.
- Both ports may read the same address in the same cycle.

Priority:
- clr in IDLE beats we/re_a/re_b in the same cycle: the write is dropped and no rvalid is produced.
- While busy=1, we/re_x are ignored, rvalid_x=0, and rdata_x holds its value.

Export:
- rf_data is combinational from register contents and reflects a write from the cycle after the edge.
- During CLEAR it shows progressive zeroing.

Reset mid-operation:
- rst during CLEAR aborts the sequence; all registers are 0 and busy=0 immediately (asynchronous).

Test Plan:
- Reset then read all 16 addresses on A and B -> every rdata=0x00, rvalid pulses 1 cycle after each re; busy=0; rf_data=0.
- Write reg3=0xA5 and reg4=0x3C, then read A=3 and B=4 in the same cycle -> next cycle rdata_a=0xA5, rdata_b=0x3C, both rvalid=1; rf_data[39:24]=0x3CA5.
- Same cycle: we=1, waddr=7, wdata=0x5A, re_a=1, raddr_a=7 (reg7 previously 0x11) -> rdata_a=0x5A next cycle; subsequent read of reg7 also gives 0x5A.
- Fill all registers with 0xFF, pulse clr with we=1 to reg2 in the same cycle -> busy high for exactly 16 cycles; reads and writes during busy produce no rvalid and change nothing; all registers read 0x00 afterwards; the reg2 write is lost; a second clr mid-sequence does not extend busy.
- Assert rst at clear cycle 5 with registers preloaded 0xFF -> busy=0 and all rf_data=0 without waiting for a clock edge; after release, reads return 0.
- Re-run with WIDTH=16, DEPTH=12, NEXPORT=3: write reg11=0xBEEF, read 11 -> 0xBEEF; read raddr 13 -> 0x0000 with rvalid=1; write to 14 has no effect; clr gives busy for 12 cycles.
